// File: rtl/line_clock_kw11l_if.sv
// Bus bundle for the KW11-L line clock: LKS Wishbone slave port and vectored-interrupt handshake.
interface line_clock_kw11l_if;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;
  logic        istb_i;
  logic        iack_o;
  logic [8:0]  ivec_o;

  modport slave (
    input  wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, istb_i,
    output wb_dat_o, wb_ack_o, irq_o, iack_o, ivec_o
  );

  modport master (
    output wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, istb_i,
    input  wb_dat_o, wb_ack_o, irq_o, iack_o, ivec_o
  );
endinterface

// File: rtl/line_clock_kw11l.sv
// KW11-L line clock: RATE Hz tick divider, debounced on/off button, gated EVNT pulse.
// Define LCLK_CSR_EN to add the LKS register (177546), Wishbone slave and vectored interrupt.
module line_clock_kw11l #(
  parameter int         CLKREF  = 50000000,
  parameter int         RATE    = 50,
  parameter int         DBDEPTH = 2,
  parameter bit         INIT_ON = 1'b1,
  parameter logic [8:0] VECTOR  = 9'o100
) (
  input  logic clk_p,
  input  logic rst,
  input  logic button,
  output logic timer_status,
  output logic evnt_o,
  line_clock_kw11l_if.slave bus
);
  localparam int LIMIT = CLKREF / RATE - 1;
  localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0]      cnt;
  logic               tick;
  logic [1:0]         btn_sync;
  logic [DBDEPTH-1:0] shift;
  logic [DBDEPTH:0]   shift_ext;
  logic [DBDEPTH-1:0] shift_nxt;
  logic               latch;
  logic               unused_shift_top;

  assign shift_ext        = {shift, btn_sync[1]};
  assign shift_nxt        = shift_ext[DBDEPTH-1:0];
  assign unused_shift_top = shift_ext[DBDEPTH];

  // The button is asynchronous: two flops before it reaches the tick-rate debouncer.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      tick         <= 1'b0;
      btn_sync     <= '0;
      shift        <= '0;
      latch        <= 1'b0;
      timer_status <= INIT_ON;
      evnt_o       <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], button};
      if (cnt == CW'(LIMIT)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
      evnt_o <= tick & timer_status;
      if (tick) begin
        shift <= shift_nxt;
        if ((&shift_nxt) && !latch) begin
          timer_status <= ~timer_status;
          latch        <= 1'b1;
        end else if (~|shift_nxt) begin
          latch <= 1'b0;
        end
      end
    end
  end

`ifdef LCLK_CSR_EN
  typedef enum logic [0:0] {S_IDLE, S_ACK} vstate_t;

  vstate_t     state, state_nxt;
  logic        ie, mon, pend, ack, irq, iack;
  logic [15:0] rdat;
  logic [8:0]  ivec;
  logic        wr, ie_nxt, pend_nxt, accept;
  logic        unused_bus;

  assign unused_bus = ^{bus.wb_dat_i[15:8], bus.wb_dat_i[5:0], bus.wb_sel_i[1]};

  // Writes commit at the edge that closes the ack cycle.
  assign wr     = ack & bus.wb_stb_i & bus.wb_we_i & bus.wb_sel_i[0];
  assign ie_nxt = wr ? bus.wb_dat_i[6] : ie;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (bus.istb_i && irq) begin
        state_nxt = S_ACK;
        accept    = 1'b1;
      end
      S_ACK:  if (!bus.istb_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new tick outranks the vector clearing the request, so no tick is lost.
  always_comb begin
    pend_nxt = pend;
    if (!ie_nxt)     pend_nxt = 1'b0;
    else if (evnt_o) pend_nxt = 1'b1;
    else if (accept) pend_nxt = 1'b0;
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ie    <= 1'b0;
      mon   <= 1'b0;
      pend  <= 1'b0;
      ack   <= 1'b0;
      irq   <= 1'b0;
      iack  <= 1'b0;
      rdat  <= '0;
      ivec  <= '0;
    end else begin
      state <= state_nxt;
      ack   <= bus.wb_stb_i & ~ack;
      rdat  <= (bus.wb_stb_i & ~ack) ? {8'b0, mon, ie, 6'b0} : 16'b0;
      ie    <= ie_nxt;
      if (evnt_o)                        mon <= 1'b1;
      else if (wr && !bus.wb_dat_i[7])   mon <= 1'b0;
      pend  <= pend_nxt;
      irq   <= pend_nxt & ie_nxt;
      iack  <= (state_nxt == S_ACK);
      ivec  <= (state_nxt == S_ACK) ? VECTOR : 9'b0;
    end
  end

  assign bus.wb_ack_o = ack;
  assign bus.wb_dat_o = rdat;
  assign bus.irq_o    = irq;
  assign bus.iack_o   = iack;
  assign bus.ivec_o   = ivec;
`else
  logic unused_bus;

  assign unused_bus   = ^{bus.wb_stb_i, bus.wb_we_i, bus.wb_sel_i, bus.wb_dat_i, bus.istb_i};
  assign bus.wb_ack_o = 1'b0;
  assign bus.wb_dat_o = 16'b0;
  assign bus.irq_o    = 1'b0;
  assign bus.iack_o   = 1'b0;
  assign bus.ivec_o   = 9'b0;
`endif
endmodule

// File: tb/tb_line_clock_kw11l.sv
// Self-checking bench for line_clock_kw11l at CLKREF=1000, RATE=50 (tick every 20 cycles).
module tb_line_clock_kw11l;
  localparam int         CLKREF  = 1000;
  localparam int         RATE    = 50;
  localparam int         DBDEPTH = 2;
  localparam int         PER     = CLKREF / RATE;
  localparam logic [8:0] VEC     = 9'o100;

  logic clk_p = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic timer_status, evnt_o;

  line_clock_kw11l_if bus();

  line_clock_kw11l #(
    .CLKREF(CLKREF), .RATE(RATE), .DBDEPTH(DBDEPTH), .INIT_ON(1'b1), .VECTOR(VEC)
  ) dut (
    .clk_p(clk_p), .rst(rst), .button(button),
    .timer_status(timer_status), .evnt_o(evnt_o), .bus(bus)
  );

  always #5 clk_p = ~clk_p;

  typedef struct packed {
    bit       btn;
    bit [7:0] ticks;
    bit       exp_status;
  } vec_t;

  int total = 0;
  int bad = 0;
  int n = 0;
  bit hist[$];
  bit smp[$];
  bit m_status, m_latch, m_evnt;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // Reference: ticks land every PER cycles from reset; the button seen at a tick is the one
  // driven two cycles earlier; DBDEPTH equal samples toggle the status once per press.
  task automatic model_reset();
    n = 0;
    hist.delete();
    hist.push_back(1'b0);
    smp.delete();
    for (int i = 0; i < DBDEPTH; i++) smp.push_back(1'b0);
    m_status = 1'b1;
    m_latch  = 1'b0;
    m_evnt   = 1'b0;
  endtask

  task automatic model_edge();
    bit ones, zeros;
    m_evnt = 1'b0;
    if (n >= PER + 1 && (n - 1) % PER == 0) begin
      m_evnt = m_status;
      smp.push_back(hist[n-2]);
      void'(smp.pop_front());
      ones = 1'b1;
      zeros = 1'b1;
      foreach (smp[i]) begin
        if (smp[i]) zeros = 1'b0;
        else        ones  = 1'b0;
      end
      if (ones && !m_latch) begin
        m_status = !m_status;
        m_latch  = 1'b1;
      end else if (zeros) begin
        m_latch = 1'b0;
      end
    end
  endtask

  task automatic step(input bit b);
    button = b;
    @(posedge clk_p);
    n++;
    hist.push_back(b);
    model_edge();
    @(negedge clk_p);
    check("evnt_o", evnt_o, m_evnt);
    check("timer_status", timer_status, m_status);
`ifndef LCLK_CSR_EN
    check("tied_outputs", {bus.wb_ack_o, bus.wb_dat_o, bus.irq_o, bus.iack_o, bus.ivec_o}, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk_p);
    rst = 1'b1;
    button = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 2'b00;
    bus.wb_dat_i = 16'h0;
    bus.istb_i = 1'b0;
    #1;
    check("rst_status", timer_status, 1);
    check("rst_evnt", evnt_o, 0);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    check("rst_irq", bus.irq_o, 0);
    check("rst_iack", bus.iack_o, 0);
    check("rst_ivec", bus.ivec_o, 0);
    @(posedge clk_p);
    @(negedge clk_p);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_evnt();
    int k;
    k = 0;
    while (evnt_o !== 1'b1 && k < 2 * PER) begin
      step(1'b0);
      k++;
    end
    check("evnt_seen", evnt_o, 1);
  endtask

`ifdef LCLK_CSR_EN
  task automatic wb_write(input logic [15:0] d, input logic [1:0] s);
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b1;
    bus.wb_sel_i = s;
    bus.wb_dat_i = d;
    step(1'b0);
    check("wr_ack", bus.wb_ack_o, 1);
    step(1'b0);
    check("wr_ack_drop", bus.wb_ack_o, 0);
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_read(string nm, input logic [15:0] exp);
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b0;
    step(1'b0);
    check({nm, "_ack"}, bus.wb_ack_o, 1);
    check(nm, bus.wb_dat_o, exp);
    step(1'b0);
    check({nm, "_idle_dat"}, bus.wb_dat_o, 0);
    bus.wb_stb_i = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[7];
    int   first, cntp, last, len;
    bit   gap_ok, rb;

    tbl[0] = '{btn: 1'b1, ticks: 8'd2,  exp_status: 1'b0};
    tbl[1] = '{btn: 1'b1, ticks: 8'd10, exp_status: 1'b0};
    tbl[2] = '{btn: 1'b0, ticks: 8'd2,  exp_status: 1'b0};
    tbl[3] = '{btn: 1'b1, ticks: 8'd2,  exp_status: 1'b1};
    tbl[4] = '{btn: 1'b0, ticks: 8'd2,  exp_status: 1'b1};
    tbl[5] = '{btn: 1'b1, ticks: 8'd1,  exp_status: 1'b1};
    tbl[6] = '{btn: 1'b0, ticks: 8'd2,  exp_status: 1'b1};

    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 2'b00;
    bus.wb_dat_i = 16'h0;
    bus.istb_i = 1'b0;
    model_reset();

    // Free-running divider: first pulse at cycle PER+1, then every PER cycles.
    do_reset();
    first = -1;
    last = -1;
    cntp = 0;
    gap_ok = 1'b1;
    for (int i = 0; i < 3 * PER + 1; i++) begin
      step(1'b0);
      if (evnt_o === 1'b1) begin
        if (first < 0) first = n;
        else if (n - last != PER) gap_ok = 1'b0;
        last = n;
        cntp++;
      end
    end
    check("first_evnt_cycle", first, PER + 1);
    check("evnt_count", cntp, 3);
    check("evnt_period", gap_ok, 1);

    // Button table: rows start mid-period so each row spans exactly 'ticks' samples.
    do_reset();
    while (n % PER != PER / 2) step(1'b0);
    foreach (tbl[i]) begin
      for (int c = 0; c < int'(tbl[i].ticks) * PER; c++) step(tbl[i].btn);
      check($sformatf("vec%0d_status", i), timer_status, tbl[i].exp_status);
    end

`ifndef LCLK_CSR_EN
    do_reset();
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 2'b11;
    bus.wb_dat_i = 16'hffff;
    bus.istb_i = 1'b1;
    repeat (10) step(1'b0);
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.istb_i = 1'b0;
`else
    // Enable, take a tick, clear MON, then service the vector.
    do_reset();
    wb_write(16'o100, 2'b11);
    wait_evnt();
    step(1'b0);
    check("irq_after_evnt", bus.irq_o, 1);
    wb_read("lks_mon_ie", 16'o300);
    wb_write(16'o100, 2'b11);
    wb_read("lks_ie", 16'o100);
    check("irq_held", bus.irq_o, 1);
    bus.istb_i = 1'b1;
    step(1'b0);
    check("iack_set", bus.iack_o, 1);
    check("ivec_val", bus.ivec_o, VEC);
    check("irq_cleared", bus.irq_o, 0);
    step(1'b0);
    check("iack_held", bus.iack_o, 1);
    bus.istb_i = 1'b0;
    step(1'b0);
    check("iack_drop", bus.iack_o, 0);
    check("ivec_drop", bus.ivec_o, 0);
    bus.istb_i = 1'b1;
    step(1'b0);
    check("iack_no_irq", bus.iack_o, 0);
    bus.istb_i = 1'b0;

    // IE cleared by a write whose ack cycle coincides with evnt_o.
    do_reset();
    wb_write(16'o100, 2'b11);
    while (n != PER) step(1'b0);
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 2'b11;
    bus.wb_dat_i = 16'o000;
    step(1'b0);
    check("same_cycle_ack", bus.wb_ack_o, 1);
    check("same_cycle_evnt", evnt_o, 1);
    step(1'b0);
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    check("no_irq_same_cycle", bus.irq_o, 0);
    wb_read("lks_mon_only", 16'o200);
    check("no_irq_later", bus.irq_o, 0);
    wb_write(16'o100, 2'b10);
    wb_read("lks_sel_hi", 16'o200);

    // Reset while the vector handshake is in ACK.
    do_reset();
    wb_write(16'o100, 2'b11);
    wait_evnt();
    step(1'b0);
    check("irq_before_ack", bus.irq_o, 1);
    bus.istb_i = 1'b1;
    step(1'b0);
    check("iack_before_rst", bus.iack_o, 1);
    do_reset();
    step(1'b0);
    check("iack_after_rst", bus.iack_o, 0);
`endif

    // Random button runs with occasional reset, checked cycle by cycle against the model.
    do_reset();
    for (int seg = 0; seg < 80; seg++) begin
      rb = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 3 * PER));
      if ($urandom_range(0, 19) == 0) do_reset();
      for (int c = 0; c < len; c++) begin
`ifndef LCLK_CSR_EN
        bus.wb_stb_i = 1'($urandom_range(0, 1));
        bus.wb_we_i = 1'($urandom_range(0, 1));
        bus.istb_i = 1'($urandom_range(0, 1));
        bus.wb_dat_i = 16'($urandom);
`endif
        step(rb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
